// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer with PC, imem req/ack handshake, skid slot, redirect/flush; optional timeout via FETCH_TIMEOUT_EN
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_line_out,
  output logic [31:0] instruct_data_line_out,
  output logic        if_valid,
  output logic        if_flush,
  output logic        fetch_err
);
  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, ERR} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, pco_q, pco_d, ins_q, ins_d;
  logic [31:0] skpc_q, skpc_d, skins_q, skins_d;
  logic req_q, req_d, valid_q, valid_d, flush_q, flush_d, skv_q, skv_d, err_q, err_d;
  logic ack, consume, slot_ok;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  assign ack     = req_q & imem_ack;
  assign consume = valid_q & ~stall_in;
  assign slot_ok = ~valid_q | ~stall_in;
  assign imem_req               = req_q;
  assign imem_addr              = addr_q;
  assign PC_line_out            = pco_q;
  assign instruct_data_line_out = ins_q;
  assign if_valid               = valid_q;
  assign if_flush               = flush_q;
  assign fetch_err              = err_q;
  // next-state: sequencing, then redirect override, then timeout override
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pco_d   = pco_q;
    ins_d   = ins_q;
    valid_d = valid_q;
    flush_d = 1'b0;
    skv_d   = skv_q;
    skpc_d  = skpc_q;
    skins_d = skins_q;
    err_d   = err_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = (req_q && !imem_ack) ? cnt_q + CW'(1) : '0;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      FETCH: begin
        if (consume) valid_d = 1'b0;
        if (ack) begin
          pc_d = pc_q + 32'd4;
          if (slot_ok) begin
            pco_d   = addr_q;
            ins_d   = imem_rdata;
            valid_d = 1'b1;
            addr_d  = pc_q + 32'd4;
          end else begin
            skv_d   = 1'b1;
            skpc_d  = addr_q;
            skins_d = imem_rdata;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          pco_d   = skpc_q;
          ins_d   = skins_q;
          valid_d = 1'b1;
          skv_d   = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (ack) begin
          state_d = FETCH;
          addr_d  = pc_q;
        end
      end
      default: ;
    endcase
    if (redirect_valid && state_q != ERR) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      skv_d   = 1'b0;
      flush_d = 1'b1;
      pco_d   = pco_q;
      ins_d   = ins_q;
      req_d   = 1'b1;
      state_d = (req_q && !imem_ack) ? DRAIN : FETCH;
      addr_d  = (req_q && !imem_ack) ? addr_q : {redirect_pc[31:2], 2'b00};
    end
`ifdef FETCH_TIMEOUT_EN
    if (req_q && !imem_ack && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
      state_d = ERR;
      req_d   = 1'b0;
      valid_d = 1'b0;
      skv_d   = 1'b0;
      flush_d = 1'b0;
      err_d   = 1'b1;
    end
`endif
  end
  // state and output registers, async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pco_q   <= '0;
      ins_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      skv_q   <= 1'b0;
      skpc_q  <= '0;
      skins_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pco_q   <= pco_d;
      ins_q   <= ins_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      skv_q   <= skv_d;
      skpc_q  <= skpc_d;
      skins_q <= skins_d;
      err_q   <= err_d;
    end
  end
`ifdef FETCH_TIMEOUT_EN
  // consecutive unacked-request cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: queue-based fetch model with per-cycle compare plus directed literal checks
module tb_fetch_ctrl;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic stall_in = 1'b0, redirect_valid = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, if_valid, if_flush, fetch_err;
  logic [31:0] imem_addr, PC_line_out, instruct_data_line_out;
  int checks = 0, errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_line_out(PC_line_out),
    .instruct_data_line_out(instruct_data_line_out), .if_valid(if_valid),
    .if_flush(if_flush), .fetch_err(fetch_err));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t q[$];
  bit m_started, m_req, m_discard, m_flush, m_err;
  logic [31:0] m_addr, m_next;
  int m_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // presented slot = queue head; queue holds output slot plus skid (max 2)
  task automatic model_step();
    bit got;
    if (rst) begin
      q.delete();
      m_started = 0; m_req = 0; m_discard = 0; m_flush = 0; m_err = 0;
      m_addr = 32'h0; m_next = 32'h0; m_miss = 0;
      return;
    end
    if (m_err) begin
      m_flush = 0;
      return;
    end
    got = m_req && imem_ack;
    if (q.size() > 0 && !stall_in) void'(q.pop_front());
    if (got && !m_discard) begin
      q.push_back('{m_addr, imem_rdata});
      m_next = m_addr + 32'd4;
    end
    if (got) m_discard = 0;
    m_flush = redirect_valid;
    if (redirect_valid) begin
      q.delete();
      m_next = {redirect_pc[31:2], 2'b00};
      if (m_req && !imem_ack) m_discard = 1;
    end
    m_miss = (m_req && !imem_ack) ? m_miss + 1 : 0;
    if (!m_started) begin
      m_started = 1; m_req = 1; m_addr = m_next;
    end else if (!(m_req && !got)) begin
      m_req = q.size() < 2;
      if (m_req) m_addr = m_next;
    end
`ifdef FETCH_TIMEOUT_EN
    if (m_miss == TO) begin
      m_err = 1; m_req = 0; m_flush = 0; q.delete();
    end
`endif
  endtask

  // compare DUT against model every cycle
  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_req", imem_req, m_req);
    if (m_req) chk("m_addr", imem_addr, m_addr);
    chk("m_valid", if_valid, q.size() > 0);
    chk("m_flush", if_flush, m_flush);
    chk("m_err", fetch_err, m_err);
    if (q.size() > 0) begin
      chk("m_pc", PC_line_out, q[0].pc);
      chk("m_ins", instruct_data_line_out, q[0].ins);
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [31:0] p, input logic a);
    stall_in = s; redirect_valid = r; redirect_pc = p; imem_ack = a; imem_rdata = $urandom;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", PC_line_out, 0);
    chk("rst_ins", instruct_data_line_out, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_flush", if_flush, 0);
    chk("rst_err", fetch_err, 0);
    rst = 1'b0;
    // back-to-back 0-wait fetch
    cyc(0, 0, 0, 1);
    chk("t1_req", imem_req, 1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", if_valid, 0);
    cyc(0, 0, 0, 1);
    chk("t1_valid1", if_valid, 1);
    chk("t1_pc0", PC_line_out, 32'h0);
    chk("t1_addr4", imem_addr, 32'h4);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("t1_pc12", PC_line_out, 32'hC);
    chk("t1_addr16", imem_addr, 32'h10);
    // stall with ack -> skid and HOLD
    cyc(1, 0, 0, 0);
    chk("t2_frozen_pc", PC_line_out, 32'hC);
    chk("t2_req_out", imem_req, 1);
    cyc(1, 0, 0, 1);
    chk("t2_hold_req", imem_req, 0);
    chk("t2_hold_pc", PC_line_out, 32'hC);
    cyc(1, 0, 0, 1);
    chk("t2_hold_req2", imem_req, 0);
    cyc(0, 0, 0, 0);
    chk("t2_skid_pc", PC_line_out, 32'h10);
    chk("t2_skid_valid", if_valid, 1);
    chk("t2_resume_req", imem_req, 1);
    chk("t2_resume_addr", imem_addr, 32'h14);
    // redirect with outstanding req -> drain
    cyc(0, 1, 32'h0000_0103, 0);
    chk("t3_flush", if_flush, 1);
    chk("t3_valid", if_valid, 0);
    chk("t3_addr_hold", imem_addr, 32'h14);
    cyc(0, 0, 0, 0);
    chk("t3_flush_end", if_flush, 0);
    chk("t3_addr_hold2", imem_addr, 32'h14);
    cyc(0, 0, 0, 1);
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_discard", if_valid, 0);
    cyc(0, 0, 0, 1);
    chk("t3_pc", PC_line_out, 32'h100);
    // redirect coinciding with ack, then back-to-back redirects
    cyc(0, 1, 32'h200, 1);
    chk("t4_flush", if_flush, 1);
    chk("t4_drop", if_valid, 0);
    chk("t4_addr", imem_addr, 32'h200);
    cyc(0, 1, 32'h300, 0);
    chk("t4_flush2", if_flush, 1);
    cyc(0, 1, 32'h404, 0);
    chk("t4_flush3", if_flush, 1);
    chk("t4_addr_hold", imem_addr, 32'h200);
    cyc(0, 0, 0, 1);
    chk("t4_flush_end", if_flush, 0);
    chk("t4_addr_last", imem_addr, 32'h404);
    cyc(0, 0, 0, 1);
    chk("t4_pc", PC_line_out, 32'h404);
    // PC wrap
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("t5_pc", PC_line_out, 32'hFFFF_FFFC);
    chk("t5_wrap", imem_addr, 32'h0);
    // mixed stimulus checked by the model
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = !m_discard && ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 2) == 0, r, $urandom, $urandom_range(0, 2) != 0);
    end
    cyc(0, 1, 32'h800, 0);
    cyc(0, 0, 0, 1);
    // timeout
    for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0);
    chk("t6_no_err_yet", fetch_err, 0);
    cyc(0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
    chk("t6_err", fetch_err, 1);
    chk("t6_req", imem_req, 0);
    cyc(0, 1, 32'h50, 0);
    chk("t6_redir_ign", if_flush, 0);
    chk("t6_err_sticky", fetch_err, 1);
`else
    chk("t6_err_off", fetch_err, 0);
    chk("t6_req_off", imem_req, 1);
`endif
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk("t6_rst_err", fetch_err, 0);
    chk("t6_rst_req", imem_req, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("t6_restart_pc", PC_line_out, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
